shift_cmd_queue: RTL and testbench

SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

---
 rtl/shift_cmd_queue.sv | 119 +++++++++++
 tb/tb_shift_cmd_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: DEPTH-entry show-ahead FIFO of {CTRL,D} commands feeding a shifter-rotator.
// Define SHIFT_CMD_QUEUE_BYPASS_EN to let a command offered to an empty queue pass straight through.
module shift_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [3:0]               IN_D,
    input  logic [2:0]               IN_CTRL,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [3:0]               OUT_D,
    output logic [2:0]               OUT_CTRL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [7:0]               ISSUED
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    issued_q, issued_d;

    logic       in_ready_s;
    logic       out_valid_s;
    logic       bypass_s;
    logic       push_s;
    logic       pop_s;
    logic       store_s;
    logic       unload_s;
    logic [6:0] head_s;

    // Handshake decode, head selection and next-state for pointers/counters.
    always_comb begin
        in_ready_s = (count_q != FULL_CNT) && !FLUSH;
`ifdef SHIFT_CMD_QUEUE_BYPASS_EN
        bypass_s   = (count_q == {CW{1'b0}}) && !FLUSH && IN_VALID;
`else
        bypass_s   = 1'b0;
`endif
        out_valid_s = ((count_q != {CW{1'b0}}) && !FLUSH) || bypass_s;
        if (bypass_s) begin
            head_s = {IN_CTRL, IN_D};
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
        push_s   = IN_VALID && in_ready_s;
        pop_s    = out_valid_s && OUT_READY;
        // A bypassed command that is consumed immediately never touches storage.
        store_s  = push_s && !(bypass_s && OUT_READY);
        unload_s = pop_s && !bypass_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        if (FLUSH) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (store_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (unload_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({store_s, unload_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (pop_s) begin
                issued_d = issued_q + 8'd1;
            end else begin
                issued_d = issued_q;
            end
        end
    end

    // Pointer, occupancy and issue-count registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            issued_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    // Command storage; contents are not reset.
    always_ff @(posedge CLK) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= {IN_CTRL, IN_D};
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_s;
    assign OUT_CTRL  = head_s[6:4];
    assign OUT_D     = head_s[3:0];
    assign COUNT     = count_q;
    assign ISSUED    = issued_q;
endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_shift_cmd_queue;
    localparam int DEPTH = 4;
`ifdef SHIFT_CMD_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FLUSH = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] IN_D = 4'd0;
    logic [2:0] IN_CTRL = 3'd0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [3:0] OUT_D;
    logic [2:0] OUT_CTRL;
    logic [2:0] COUNT;
    logic [7:0] ISSUED;

    int total = 0;
    int bad = 0;

    shift_cmd_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_D(IN_D), .IN_CTRL(IN_CTRL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_D(OUT_D), .OUT_CTRL(OUT_CTRL),
        .COUNT(COUNT), .ISSUED(ISSUED)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {CTRL,D} words and an issue counter.
    logic [6:0] mq[$];
    int         m_issued = 0;
    bit         n_unload, n_store, n_pop;
    logic [6:0] n_word;

    initial forever begin
        bit         e_ready, e_valid, e_byp;
        logic [6:0] e_head;
        @(negedge CLK);
        e_ready = !FLUSH && (mq.size() != DEPTH);
        e_byp   = BYP && (mq.size() == 0) && !FLUSH && IN_VALID;
        e_valid = (!FLUSH && mq.size() != 0) || e_byp;
        e_head  = e_byp ? {IN_CTRL, IN_D} : ((mq.size() != 0) ? mq[0] : 7'd0);
        check("in_ready", 32'(IN_READY), 32'(e_ready));
        check("out_valid", 32'(OUT_VALID), 32'(e_valid));
        check("count", 32'(COUNT), 32'(mq.size()));
        check("issued", 32'(ISSUED), 32'(m_issued & 255));
        if (e_valid) check("head", 32'({OUT_CTRL, OUT_D}), 32'(e_head));
        n_pop    = e_valid && OUT_READY;
        n_unload = n_pop && !e_byp;
        n_store  = IN_VALID && e_ready && !(e_byp && OUT_READY);
        n_word   = {IN_CTRL, IN_D};
    end

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            mq.delete();
            m_issued = 0;
        end else if (FLUSH) begin
            mq.delete();
        end else begin
            if (n_unload) void'(mq.pop_front());
            if (n_store) mq.push_back(n_word);
            if (n_pop) m_issued = m_issued + 1;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        cyc();
        RST = 1'b0;
    endtask

    task automatic push_word(input logic [6:0] w);
        IN_VALID = 1'b1;
        {IN_CTRL, IN_D} = w;
        cyc();
        IN_VALID = 1'b0;
    endtask

    logic [6:0] words [5];

    initial begin
        words[0] = 7'b001_0001;
        words[1] = 7'b010_0010;
        words[2] = 7'b101_1100;
        words[3] = 7'b111_1111;
        words[4] = 7'b100_0101;

        // Reset state
        #1;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_issued", 32'(ISSUED), 32'd0);
        cyc();
        RST = 1'b0;
        cyc();

        // First push latency
        push_word(7'b101_1011);
        check("lat_valid", 32'(OUT_VALID), 32'd1);
        check("lat_d", 32'(OUT_D), 32'b1011);
        check("lat_ctrl", 32'(OUT_CTRL), 32'b101);
        check("lat_count", 32'(COUNT), 32'd1);
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;

        // Fill past full, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_word(words[i]);
            if (i == 3) check("full_in_ready", 32'(IN_READY), 32'd0);
        end
        check("full_count", 32'(COUNT), 32'd4);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_word", 32'({OUT_CTRL, OUT_D}), 32'(words[i]));
            cyc();
        end
        OUT_READY = 1'b0;
        check("drain_issued", 32'(ISSUED), 32'd4);
        check("drain_empty", 32'(OUT_VALID), 32'd0);

        // Full queue with simultaneous offer and pop: pop only
        do_reset();
        for (int i = 0; i < 4; i++) push_word(words[i]);
        IN_VALID = 1'b1; {IN_CTRL, IN_D} = words[4]; OUT_READY = 1'b1;
        cyc();
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        check("fullpop_count", 32'(COUNT), 32'd3);
        check("fullpop_ready", 32'(IN_READY), 32'd1);
        check("fullpop_head", 32'({OUT_CTRL, OUT_D}), 32'(words[1]));

        // Streaming push+pop across pointer wrap
        do_reset();
        push_word(words[2]);
        push_word(words[3]);
        OUT_READY = 1'b1;
        for (int i = 0; i < 300; i++) begin
            IN_VALID = 1'b1;
            {IN_CTRL, IN_D} = 7'(i * 37 + 11);
            cyc();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        check("stream_count", 32'(COUNT), 32'd2);
        check("stream_issued", 32'(ISSUED), 32'd44);

        // Flush priority
        do_reset();
        for (int i = 0; i < 4; i++) push_word(words[i]);
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;
        check("preflush_count", 32'(COUNT), 32'd3);
        FLUSH = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        check("flush_in_ready", 32'(IN_READY), 32'd0);
        check("flush_out_valid", 32'(OUT_VALID), 32'd0);
        cyc();
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        check("flush_count", 32'(COUNT), 32'd0);
        check("flush_issued", 32'(ISSUED), 32'd1);

        // Asynchronous reset mid-burst
        IN_VALID = 1'b1; {IN_CTRL, IN_D} = words[0];
        cyc();
        cyc();
        #2;
        RST = 1'b1;
        #1;
        check("async_count", 32'(COUNT), 32'd0);
        check("async_issued", 32'(ISSUED), 32'd0);
        IN_VALID = 1'b0;
        cyc();
        RST = 1'b0;
        IN_VALID = 1'b1; {IN_CTRL, IN_D} = words[2];
`ifndef SHIFT_CMD_QUEUE_BYPASS_EN
        #1;
        check("post_rst_not_yet", 32'(OUT_VALID), 32'd0);
`endif
        cyc();
        IN_VALID = 1'b0;
        check("post_rst_valid", 32'(OUT_VALID), 32'd1);
        check("post_rst_head", 32'({OUT_CTRL, OUT_D}), 32'(words[2]));
        check("post_rst_count", 32'(COUNT), 32'd1);

`ifdef SHIFT_CMD_QUEUE_BYPASS_EN
        // Bypass into an empty queue
        do_reset();
        IN_VALID = 1'b1; {IN_CTRL, IN_D} = 7'b011_0110; OUT_READY = 1'b1;
        #1;
        check("byp_valid", 32'(OUT_VALID), 32'd1);
        check("byp_d", 32'(OUT_D), 32'b0110);
        cyc();
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        check("byp_count", 32'(COUNT), 32'd0);
        check("byp_issued", 32'(ISSUED), 32'd1);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
